// File: rtl/rename_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rename_pkg : shared sizes, types and helpers for the rename block     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rename_pkg;

  localparam int NUM_PREGS = 128;
  localparam int PREG_SZ   = $clog2(NUM_PREGS);
  localparam int REN_WIDTH = 4;
  localparam int LANE_SZ   = $clog2(REN_WIDTH);
  localparam int WB_PORTS  = 10;
  localparam int NUM_CKPTS = 4;
  localparam int CKPT_SZ   = $clog2(NUM_CKPTS);

  typedef logic [PREG_SZ-1:0]   preg_t;
  typedef logic [NUM_PREGS-1:0] busy_vec_t;

  function automatic busy_vec_t onehot_preg(input preg_t p);
    onehot_preg = busy_vec_t'(1) << p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/busy_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | busy_popcount : registered population count of the busy vector       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module busy_popcount
  import rename_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  busy_vec_t        vec,
  output logic [PREG_SZ:0] count
);

  logic [PREG_SZ:0] w_sum;
  logic [PREG_SZ:0] r_count;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      w_sum = w_sum + {{PREG_SZ{1'b0}}, vec[i]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_count <= '0;
    else        r_count <= w_sum;
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rename_busy_table_ckpt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rename_busy_table_ckpt : preg busy table with intra-bundle forwarding,|
// | branch snapshots and flush. Option: BUSY_TABLE_WB_BYPASS_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
module rename_busy_table_ckpt
  import rename_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic [REN_WIDTH*PREG_SZ-1:0]  io_ren_pdst,
  input  logic [REN_WIDTH*PREG_SZ-1:0]  io_ren_prs1,
  input  logic [REN_WIDTH*PREG_SZ-1:0]  io_ren_prs2,
  input  logic [REN_WIDTH-1:0]          io_rebusy_reqs,
  output logic [REN_WIDTH-1:0]          io_busy_prs1,
  output logic [REN_WIDTH-1:0]          io_busy_prs2,
  input  logic [WB_PORTS*PREG_SZ-1:0]   io_wb_pdsts,
  input  logic [WB_PORTS-1:0]           io_wb_valids,
  input  logic                          io_ckpt_valid,
  input  logic [CKPT_SZ-1:0]            io_ckpt_idx,
  input  logic [LANE_SZ-1:0]            io_ckpt_lane,
  input  logic                          io_restore_valid,
  input  logic [CKPT_SZ-1:0]            io_restore_idx,
  input  logic                          io_flush,
  output logic [PREG_SZ:0]              io_busy_count
);

  localparam busy_vec_t c_x0_mask = busy_vec_t'(1);

  busy_vec_t r_table;
  busy_vec_t r_snap [NUM_CKPTS];
  busy_vec_t w_clear;
  busy_vec_t w_set_run;
  busy_vec_t w_set_upto [REN_WIDTH];
  busy_vec_t w_table_kept;
  busy_vec_t w_ckpt_vec;
  busy_vec_t w_table_next;
  logic      w_ckpt_take;

  always_comb begin
    w_clear = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (io_wb_valids[p]) w_clear = w_clear | onehot_preg(io_wb_pdsts[p*PREG_SZ +: PREG_SZ]);
    end
  end

  // w_set_upto[l] holds the rebusies of lanes 0..l, with x0 removed.
  always_comb begin
    w_set_run = '0;
    for (int l = 0; l < REN_WIDTH; l++) begin
      if (io_rebusy_reqs[l]) w_set_run = w_set_run | onehot_preg(io_ren_pdst[l*PREG_SZ +: PREG_SZ]);
      w_set_upto[l] = w_set_run & ~c_x0_mask;
    end
  end

  for (genvar l = 0; l < REN_WIDTH; l++) begin : g_lane
    preg_t w_prs1;
    preg_t w_prs2;
    logic  w_fwd1;
    logic  w_fwd2;
    logic  w_tbl1;
    logic  w_tbl2;

    assign w_prs1 = io_ren_prs1[l*PREG_SZ +: PREG_SZ];
    assign w_prs2 = io_ren_prs2[l*PREG_SZ +: PREG_SZ];

    if (l == 0) begin : g_first
      assign w_fwd1 = 1'b0;
      assign w_fwd2 = 1'b0;
    end else begin : g_older
      assign w_fwd1 = w_set_upto[l-1][w_prs1];
      assign w_fwd2 = w_set_upto[l-1][w_prs2];
    end

`ifdef BUSY_TABLE_WB_BYPASS_EN
    assign w_tbl1 = r_table[w_prs1] & ~w_clear[w_prs1];
    assign w_tbl2 = r_table[w_prs2] & ~w_clear[w_prs2];
`else
    assign w_tbl1 = r_table[w_prs1];
    assign w_tbl2 = r_table[w_prs2];
`endif

    // Reset gating keeps the forwarding term quiet while in reset.
    assign io_busy_prs1[l] = reset & (w_tbl1 | w_fwd1);
    assign io_busy_prs2[l] = reset & (w_tbl2 | w_fwd2);
  end

  assign w_table_kept = r_table & ~w_clear;
  assign w_ckpt_vec   = w_table_kept | w_set_upto[io_ckpt_lane];
  assign w_ckpt_take  = io_ckpt_valid & ~io_restore_valid;

  always_comb begin
    w_table_next = w_table_kept | w_set_upto[REN_WIDTH-1];
    if (io_flush)              w_table_next = '0;
    else if (io_restore_valid) w_table_next = r_snap[io_restore_idx] & ~w_clear;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_table <= '0;
    else        r_table <= w_table_next;
  end

  // Idle snapshots keep absorbing wakeups so a later restore never resurrects a done preg.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CKPTS; i++) r_snap[i] <= '0;
    end else if (!io_flush) begin
      for (int i = 0; i < NUM_CKPTS; i++) begin
        if (w_ckpt_take && io_ckpt_idx == CKPT_SZ'(i)) r_snap[i] <= w_ckpt_vec;
        else                                           r_snap[i] <= r_snap[i] & ~w_clear;
      end
    end
  end

  busy_popcount u_popcount (
    .clock (clock),
    .reset (reset),
    .vec   (r_table),
    .count (io_busy_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_rename_busy_table_ckpt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rename_busy_table_ckpt : scoreboard bench with per-preg model       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rename_busy_table_ckpt;
  import rename_pkg::*;

  typedef struct packed {
    logic [REN_WIDTH-1:0] b1;
    logic [REN_WIDTH-1:0] b2;
    logic [PREG_SZ:0]     cnt;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  preg_t                ren_pdst [REN_WIDTH];
  preg_t                ren_prs1 [REN_WIDTH];
  preg_t                ren_prs2 [REN_WIDTH];
  logic [REN_WIDTH-1:0] rebusy;
  preg_t                wb_pdst [WB_PORTS];
  logic [WB_PORTS-1:0]  wb_valid;
  logic                 ckpt_valid;
  logic [CKPT_SZ-1:0]   ckpt_idx;
  logic [LANE_SZ-1:0]   ckpt_lane;
  logic                 restore_valid;
  logic [CKPT_SZ-1:0]   restore_idx;
  logic                 flush;

  logic [REN_WIDTH*PREG_SZ-1:0] pdst_bus, prs1_bus, prs2_bus;
  logic [WB_PORTS*PREG_SZ-1:0]  wb_bus;
  logic [REN_WIDTH-1:0]         busy1, busy2;
  logic [PREG_SZ:0]             count;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit m_busy [NUM_PREGS];
  bit m_snap [NUM_CKPTS][NUM_PREGS];
  int m_cnt = 0;

  always_comb begin
    pdst_bus = '0; prs1_bus = '0; prs2_bus = '0; wb_bus = '0;
    for (int l = 0; l < REN_WIDTH; l++) begin
      pdst_bus[l*PREG_SZ +: PREG_SZ] = ren_pdst[l];
      prs1_bus[l*PREG_SZ +: PREG_SZ] = ren_prs1[l];
      prs2_bus[l*PREG_SZ +: PREG_SZ] = ren_prs2[l];
    end
    for (int p = 0; p < WB_PORTS; p++) wb_bus[p*PREG_SZ +: PREG_SZ] = wb_pdst[p];
  end

  rename_busy_table_ckpt dut (
    .clock            (clock),
    .reset            (reset),
    .io_ren_pdst      (pdst_bus),
    .io_ren_prs1      (prs1_bus),
    .io_ren_prs2      (prs2_bus),
    .io_rebusy_reqs   (rebusy),
    .io_busy_prs1     (busy1),
    .io_busy_prs2     (busy2),
    .io_wb_pdsts      (wb_bus),
    .io_wb_valids     (wb_valid),
    .io_ckpt_valid    (ckpt_valid),
    .io_ckpt_idx      (ckpt_idx),
    .io_ckpt_lane     (ckpt_lane),
    .io_restore_valid (restore_valid),
    .io_restore_idx   (restore_idx),
    .io_flush         (flush),
    .io_busy_count    (count)
  );

  always #5 clock = ~clock;

  function automatic bit wb_hits(int r);
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] && int'(wb_pdst[p]) == r) return 1'b1;
    return 1'b0;
  endfunction

  // Is preg r rebusied by any lane 0..last this cycle (x0 never counts)?
  function automatic bit set_upto(int r, int last);
    if (r == 0) return 1'b0;
    for (int l = 0; l <= last; l++)
      if (rebusy[l] && int'(ren_pdst[l]) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit read_busy(int r, int lane);
    bit t;
    t = m_busy[r];
`ifdef BUSY_TABLE_WB_BYPASS_EN
    if (wb_hits(r)) t = 1'b0;
`endif
    return t || set_upto(r, lane - 1);
  endfunction

  task automatic advance();
    bit nb [NUM_PREGS];
    bit ns [NUM_CKPTS][NUM_PREGS];
    int pop;
    bit w;
    if (!reset) begin
      for (int r = 0; r < NUM_PREGS; r++) begin
        m_busy[r] = 1'b0;
        for (int i = 0; i < NUM_CKPTS; i++) m_snap[i][r] = 1'b0;
      end
      m_cnt = 0;
      return;
    end
    pop = 0;
    for (int r = 0; r < NUM_PREGS; r++) begin
      pop += int'(m_busy[r]);
      w = wb_hits(r);
      if (flush)              nb[r] = 1'b0;
      else if (restore_valid) nb[r] = m_snap[restore_idx][r] && !w;
      else                    nb[r] = (m_busy[r] && !w) || set_upto(r, REN_WIDTH - 1);
      for (int i = 0; i < NUM_CKPTS; i++) begin
        if (flush)
          ns[i][r] = m_snap[i][r];
        else if (ckpt_valid && !restore_valid && int'(ckpt_idx) == i)
          ns[i][r] = (m_busy[r] && !w) || set_upto(r, int'(ckpt_lane));
        else
          ns[i][r] = m_snap[i][r] && !w;
      end
    end
    m_busy = nb;
    m_snap = ns;
    m_cnt  = pop;
  endtask

  task automatic commit();
    exp_t e;
    e.cnt = reset ? (PREG_SZ+1)'(m_cnt) : '0;
    for (int l = 0; l < REN_WIDTH; l++) begin
      e.b1[l] = reset && read_busy(int'(ren_prs1[l]), l);
      e.b2[l] = reset && read_busy(int'(ren_prs2[l]), l);
    end
    sb.push_back(e);
    advance();
  endtask

  task automatic slot();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    for (int l = 0; l < REN_WIDTH; l++) begin
      ren_pdst[l] = '0; ren_prs1[l] = '0; ren_prs2[l] = '0;
    end
    for (int p = 0; p < WB_PORTS; p++) wb_pdst[p] = '0;
    rebusy = '0; wb_valid = '0;
    ckpt_valid = 1'b0; ckpt_idx = '0; ckpt_lane = '0;
    restore_valid = 1'b0; restore_idx = '0; flush = 1'b0;
  endtask

  task automatic rand_inputs(int maxreg);
    for (int l = 0; l < REN_WIDTH; l++) begin
      ren_pdst[l] = preg_t'($urandom_range(0, maxreg));
      ren_prs1[l] = preg_t'($urandom_range(0, maxreg));
      ren_prs2[l] = preg_t'($urandom_range(0, maxreg));
      rebusy[l]   = ($urandom_range(0, 1) == 1);
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_pdst[p]  = preg_t'($urandom_range(0, maxreg));
      wb_valid[p] = ($urandom_range(0, 3) == 0);
    end
    ckpt_valid    = ($urandom_range(0, 5) == 0);
    ckpt_idx      = CKPT_SZ'($urandom);
    ckpt_lane     = LANE_SZ'($urandom);
    restore_valid = ($urandom_range(0, 11) == 0);
    restore_idx   = CKPT_SZ'($urandom);
    flush         = ($urandom_range(0, 39) == 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("busy_prs1", 32'(busy1), 32'(e.b1));
        check("busy_prs2", 32'(busy2), 32'(e.b2));
        check("busy_count", 32'(count), 32'(e.cnt));
      end
    end
  end

  initial begin
    idle();
    repeat (3) begin slot(); commit(); end
    slot(); reset = 1'b1; commit();

    // Rebusy 5, read it back, then watch the count follow.
    slot(); idle(); rebusy[0] = 1'b1; ren_pdst[0] = 7'd5; commit();
    slot(); idle(); ren_prs1[0] = 7'd5; commit();
    slot(); idle(); commit();

    // Intra-bundle forwarding and x0.
    slot(); idle(); rebusy[0] = 1'b1; ren_pdst[0] = 7'd9; ren_prs1[0] = 7'd9; ren_prs2[2] = 7'd9;
    rebusy[1] = 1'b1; ren_pdst[1] = 7'd0; ren_prs1[3] = 7'd0; commit();
    slot(); idle(); ren_prs1[0] = 7'd0; ren_prs2[1] = 7'd9; commit();

    // Writeback versus rebusy on the same preg.
    slot(); idle(); rebusy[0] = 1'b1; ren_pdst[0] = 7'd7; commit();
    slot(); idle(); wb_valid[0] = 1'b1; wb_pdst[0] = 7'd7; rebusy[1] = 1'b1; ren_pdst[1] = 7'd7;
    ren_prs1[0] = 7'd7; commit();
    slot(); idle(); ren_prs1[0] = 7'd7; commit();
    slot(); idle(); wb_valid[3] = 1'b1; wb_pdst[3] = 7'd7; ren_prs1[0] = 7'd7; commit();
    slot(); idle(); ren_prs1[0] = 7'd7; commit();

    // Checkpoint mid-bundle, wakeup, restore.
    slot(); idle(); ckpt_valid = 1'b1; ckpt_idx = 2'd2; ckpt_lane = 2'd1;
    for (int l = 0; l < REN_WIDTH; l++) begin rebusy[l] = 1'b1; ren_pdst[l] = preg_t'(10 + l); end
    commit();
    slot(); idle(); wb_valid[5] = 1'b1; wb_pdst[5] = 7'd10; commit();
    slot(); idle(); restore_valid = 1'b1; restore_idx = 2'd2; commit();
    slot(); idle();
    for (int l = 0; l < REN_WIDTH; l++) begin ren_prs1[l] = preg_t'(10 + l); ren_prs2[l] = preg_t'(13 - l); end
    commit();

    // Flush beats restore; restore blocks a same-cycle snapshot.
    slot(); idle(); restore_valid = 1'b1; restore_idx = 2'd2; flush = 1'b1; commit();
    slot(); idle(); ren_prs1[0] = 7'd11; commit();
    slot(); idle(); ckpt_valid = 1'b1; ckpt_idx = 2'd3; ckpt_lane = 2'd3; restore_valid = 1'b1;
    restore_idx = 2'd2;
    for (int l = 0; l < REN_WIDTH; l++) begin rebusy[l] = 1'b1; ren_pdst[l] = preg_t'(20 + l); end
    commit();
    slot(); idle(); restore_valid = 1'b1; restore_idx = 2'd3; commit();
    slot(); idle();
    for (int l = 0; l < REN_WIDTH; l++) begin ren_prs1[l] = preg_t'(20 + l); ren_prs2[l] = preg_t'(11); end
    commit();

    repeat (1500) begin
      slot(); rand_inputs(($urandom_range(0, 3) == 0) ? NUM_PREGS - 1 : 31); commit();
    end

    // Fill 40 busy pregs, snapshot them everywhere, then reset mid-stream.
    slot(); idle(); flush = 1'b1; commit();
    for (int c = 0; c < 10; c++) begin
      slot(); idle();
      for (int l = 0; l < REN_WIDTH; l++) begin rebusy[l] = 1'b1; ren_pdst[l] = preg_t'(c * 4 + l + 1); end
      commit();
    end
    for (int i = 0; i < NUM_CKPTS; i++) begin
      slot(); idle(); ckpt_valid = 1'b1; ckpt_idx = CKPT_SZ'(i); ckpt_lane = 2'd3; commit();
    end
    slot(); idle(); ren_prs1[0] = 7'd3; commit();
    slot(); rand_inputs(47); reset = 1'b0; commit();
    repeat (2) begin slot(); rand_inputs(47); commit(); end
    slot(); idle(); reset = 1'b1; commit();
    for (int i = 0; i < NUM_CKPTS; i++) begin
      slot(); idle(); restore_valid = 1'b1; restore_idx = CKPT_SZ'(i); commit();
      repeat (2) begin
        slot(); idle();
        for (int l = 0; l < REN_WIDTH; l++) begin
          ren_prs1[l] = preg_t'($urandom_range(1, 40));
          ren_prs2[l] = preg_t'($urandom_range(1, 40));
        end
        commit();
      end
    end

    slot(); idle(); commit();
    repeat (2) @(negedge clock);
    #4;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rename_busy_table_ckpt.md
Name: rename_busy_table_ckpt

Overview:
Parametrised successor of the rename-stage physical-register busy table. Tracks one busy bit per physical register: set on rename (rebusy), cleared on writeback, read by renaming uops. Adds three things the previous block lacks: intra-bundle dependency detection, per-branch checkpoint snapshots with single-cycle mispredict restore, and a full flush. Sits between the rename maptable and dispatch in the core.

Parameters:
NUM_PREGS, 128, number of physical registers; power of two, at least 32
PREG_SZ, $clog2(NUM_PREGS), width of a physical register index
REN_WIDTH, 4, uops renamed per cycle (lanes)
WB_PORTS, 10, writeback wakeup ports
NUM_CKPTS, 4, snapshot slots, indexed by branch checkpoint id
CKPT_SZ, $clog2(NUM_CKPTS), width of a checkpoint index

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
io_ren_pdst  in  REN_WIDTH*PREG_SZ  per-lane destination preg
io_ren_prs1  in  REN_WIDTH*PREG_SZ  per-lane source 1 preg
io_ren_prs2  in  REN_WIDTH*PREG_SZ  per-lane source 2 preg
io_rebusy_reqs  in  REN_WIDTH  per-lane request to mark pdst busy
io_busy_prs1  out  REN_WIDTH  per-lane prs1 busy response
io_busy_prs2  out  REN_WIDTH  per-lane prs2 busy response
io_wb_pdsts  in  WB_PORTS*PREG_SZ  writeback preg per port
io_wb_valids  in  WB_PORTS  writeback valid per port
io_ckpt_valid  in  1  take a snapshot this cycle
io_ckpt_idx  in  CKPT_SZ  slot to write
io_ckpt_lane  in  $clog2(REN_WIDTH)  branch lane; snapshot includes rebusies of lanes 0..lane
io_restore_valid  in  1  mispredict restore this cycle
io_restore_idx  in  CKPT_SZ  slot to restore from
io_flush  in  1  pipeline flush; all registers ready
io_busy_count  out  PREG_SZ+1  registered popcount of the busy table

Behaviour:
- Reset (reset low, asynchronous): busy table = 0, all snapshots = 0, io_busy_count = 0. While reset is asserted, io_busy_prs1 and io_busy_prs2 = 0.
- Clear mask W = OR over ports p where io_wb_valids[p] is set of onehot(io_wb_pdsts[p]).
- Set mask S = OR over lanes l where io_rebusy_reqs[l] is set of onehot(io_ren_pdst[l]).
- Bit 0 (preg 0 / x0) is never set: it is masked out of S and out of every snapshot.
- Read (combinational, zero latency): io_busy_prs1[l] = table[prs1] OR (some lane k<l has io_rebusy_reqs[k] set and io_ren_pdst[k]==prs1, with prs1!=0). prs2 is handled the same way. A same-lane pdst never affects that lane.
- Normal update: table' = (table & ~W) | S. When a writeback and a rebusy hit the same preg in the same cycle, the set wins.
- Snapshot: when io_ckpt_valid is set, snap[idx]' = (table & ~W) | S_upto(lane), where S_upto(lane) covers lanes 0..io_ckpt_lane only. A new snapshot overwrites the slot with no error.
- Every cycle, all snapshots not being written also get snap[i]' = snap[i] & ~W, so wakeups are never lost across a restore.
- Restore: when io_restore_valid is set, table' = snap[idx] & ~W. Rebusies in that cycle are ignored, and io_ckpt_valid is ignored.
- Flush: when io_flush is set, table' = 0. Flush beats restore, which beats normal update. Snapshots are left unchanged on flush.
- io_busy_count is the popcount of the table, registered, so it lags the table by 1 cycle.
- Arithmetic: shifts and onehots are NUM_PREGS wide. Indices are unsigned and cannot exceed NUM_PREGS-1 given PREG_SZ.

Optional Feature:
BUSY_TABLE_WB_BYPASS_EN.
- Defined: the read path also masks the current-cycle W, so a source whose writeback arrives this cycle reads not-busy: table[prs] & ~W[prs], then OR the intra-bundle term. This saves 1 cycle of wakeup latency at a timing cost.
- Undefined: the read uses the registered table only, as in Behaviour.

Decomposition:
- Shared package rename_pkg holds: NUM_PREGS, PREG_SZ, REN_WIDTH, WB_PORTS, NUM_CKPTS, the typedef preg_t (logic [PREG_SZ-1:0]), the typedef busy_vec_t (logic [NUM_PREGS-1:0]), and the function onehot_preg.
- One sub-module, busy_popcount, implements the registered popcount tree for io_busy_count.

Test Plan:
- Reset low, then release; rebusy lane0 pdst=5. Next cycle, prs1=5 on lane 0 -> busy=1, and io_busy_count=1 one cycle later.
- Same cycle: lane0 rebusies pdst=9, lane2 prs2=9 and lane0 prs1=9 -> lane2 busy=1, lane0 busy=0 (table bit clear). Rebusy pdst=0 -> preg 0 is never busy.
- Preg 7 busy. Writeback 7 and rebusy 7 in the same cycle -> next cycle busy=1. Writeback 7 alone -> next cycle busy=0. With BUSY_TABLE_WB_BYPASS_EN defined, the read of 7 in the writeback cycle = 0.
- Ckpt idx=2, lane=1, with rebusies on lanes 0..3 of pdsts 10..13. Then writeback 10, then restore idx=2 -> bits 11=1, 10=0, 12=0, 13=0.
- Restore and flush in the same cycle -> table all 0. Restore with io_ckpt_valid in the same cycle -> slot not written.
- Assert reset mid-stream with 40 busy regs -> outputs 0 immediately, count=0, and every snapshot restores to all-ready.
